// File: rtl/srl_fifo_pkg.sv
// Shared helpers for the shift-register FIFO: count width and depth legality check.
package fifo_pkg;

    function automatic int unsigned cnt_width(int unsigned dep);
        return $clog2(dep + 1);
    endfunction

    function automatic bit is_pow2(int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/srl_fifo_if.sv
// Handshake/status bundle between a FIFO user (master) and the FIFO (slave).
interface srl_fifo_if #(
    parameter int unsigned WID = 8,
    parameter int unsigned DEP = 16
) ();
    logic                                wr;
    logic [WID-1:0]                      din;
    logic                                rd;
    logic [WID-1:0]                      dout;
    logic                                empty;
    logic                                full;
    logic                                almost_full;
    logic [fifo_pkg::cnt_width(DEP)-1:0] count;
    logic                                ovf;
    logic                                unf;
    logic                                clr_err;

    modport master (
        output wr, din, rd, clr_err,
        input  dout, empty, full, almost_full, count, ovf, unf
    );

    modport slave (
        input  wr, din, rd, clr_err,
        output dout, empty, full, almost_full, count, ovf, unf
    );
endinterface

// File: rtl/srl_fifo_vtdl.sv
// Variable tap delay line: shifts d in at tap 0 when ce, reads tap a combinationally.
module vtdl #(
    parameter int unsigned WID = 8,
    parameter int unsigned DEP = 16,
    parameter int unsigned AW  = $clog2(DEP)
) (
    input  logic           clk,
    input  logic           ce,
    input  logic [WID-1:0] d,
    input  logic [AW-1:0]  a,
    output logic [WID-1:0] q
);
    // No reset so the array maps onto SRL primitives.
    logic [WID-1:0] m [DEP];

    always_ff @(posedge clk) begin
        if (ce) begin
            m[0] <= d;
            for (int i = 1; i < int'(DEP); i++) begin
                m[i] <= m[i-1];
            end
        end
    end

    assign q = m[a];
endmodule

// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO: read-side bookkeeping over a variable tap delay line.
module srl_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WID   = 8,
    parameter int unsigned DEP   = 16,
    parameter int unsigned AFULL = DEP - 2
) (
    input  logic     clk,
    input  logic     rst_n,
    srl_fifo_if.slave bus
);
    localparam int unsigned CW    = cnt_width(DEP);
    localparam int unsigned AW    = $clog2(DEP);
    localparam bit          DepOk = is_pow2(DEP);

    if (!DepOk) begin : g_bad_dep
        $error("srl_fifo: DEP must be a power of two and at least 2");
    end

    logic [CW-1:0]  count_q, count_d, count_m1;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic           empty, full, wr_ok, rd_ok;
    logic [AW-1:0]  tap;
    logic [WID-1:0] q;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEP));
    assign rd_ok = bus.rd & ~empty;
    // A pop frees the slot the shift overwrites, so writes into a full FIFO may proceed.
    assign wr_ok = bus.wr & (~full | rd_ok);

    assign count_m1 = count_q - CW'(1);
    assign tap      = count_m1[AW-1:0];

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A fresh error on the same edge as clr_err must still be recorded.
        ovf_d = (ovf_q & ~bus.clr_err) | (bus.wr & ~wr_ok);
        unf_d = (unf_q & ~bus.clr_err) | (bus.rd & ~rd_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    vtdl #(
        .WID (WID),
        .DEP (DEP),
        .AW  (AW)
    ) u_vtdl (
        .clk (clk),
        .ce  (wr_ok),
        .d   (bus.din),
        .a   (tap),
        .q   (q)
    );

    assign bus.dout        = empty ? '0 : q;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = (count_q >= CW'(AFULL));
    assign bus.count       = count_q;
    assign bus.ovf         = ovf_q;
    assign bus.unf         = unf_q;
endmodule

// File: tb/tb_srl_fifo.sv
// Self-checking bench for srl_fifo against a queue-based reference model.
module tb_srl_fifo;
    localparam int unsigned DEP   = 16;
    localparam int unsigned AFULL = DEP - 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    srl_fifo_if #(.WID(8), .DEP(DEP)) bus ();

    srl_fifo #(.WID(8), .DEP(DEP), .AFULL(AFULL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: oldest entry at the front of the queue.
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    function automatic logic [7:0] m_dout();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    // Drive one clock's worth of inputs, let the edge happen, then advance the model.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
        bit rok, wok;
        bus.wr = w; bus.din = d; bus.rd = r; bus.clr_err = c;
        rok = r && (mq.size() > 0);
        wok = w && ((mq.size() < DEP) || rok);
        @(posedge clk);
        #1;
        if (rok) void'(mq.pop_front());
        if (wok) mq.push_back(d);
        m_ovf = (m_ovf && !c) || (w && !wok);
        m_unf = (m_unf && !c) || (r && !rok);
        bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp += 7;
        if (bus.count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
        if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus.full); end
        if (bus.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", bus.almost_full); end
        if (bus.dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", bus.dout); end
        if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
        if (bus.unf !== 1'b0) begin n_err++; $display("FAIL reset_unf got %b want 0", bus.unf); end
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        n_cmp++;
        if (bus.count !== 5'd5) begin n_err++; $display("FAIL prefill_count got %0d want 5", bus.count); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (bus.count !== 5'd0) begin n_err++; $display("FAIL async_rst_count got %0d want 0", bus.count); end
        if (bus.dout !== 8'h00) begin n_err++; $display("FAIL async_rst_dout got %h want 00", bus.dout); end
        mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_order();
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        n_cmp++;
        if (bus.dout !== 8'h11) begin n_err++; $display("FAIL fwft_latency got %h want 11", bus.dout); end
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.dout !== exp[i]) begin n_err++; $display("FAIL pop_%0d got %h want %h", i, bus.dout, exp[i]); end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++;
        if (bus.empty !== 1'b1) begin n_err++; $display("FAIL order_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < int'(DEP); i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            n_cmp += 2;
            if (bus.almost_full !== (i + 1 >= int'(AFULL))) begin
                n_err++; $display("FAIL afull_at_%0d got %b", i + 1, bus.almost_full);
            end
            if (bus.full !== (i + 1 == int'(DEP))) begin
                n_err++; $display("FAIL full_at_%0d got %b", i + 1, bus.full);
            end
        end
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        n_cmp += 3;
        if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", bus.ovf); end
        if (bus.count !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d want 16", bus.count); end
        if (bus.dout !== 8'h00) begin n_err++; $display("FAIL ovf_dout got %h want 00", bus.dout); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++;
        if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b want 0", bus.ovf); end
    endtask

    task automatic test_full_rw();
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        n_cmp += 3;
        if (bus.count !== 5'd16) begin n_err++; $display("FAIL full_rw_count got %0d want 16", bus.count); end
        if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL full_rw_ovf got %b want 0", bus.ovf); end
        if (bus.dout !== 8'h01) begin n_err++; $display("FAIL full_rw_dout got %h want 01", bus.dout); end
        for (int i = 0; i < int'(DEP); i++) begin
            logic [7:0] e;
            e = (i == int'(DEP) - 1) ? 8'hEE : 8'(i + 1);
            n_cmp++;
            if (bus.dout !== e) begin n_err++; $display("FAIL drain_%0d got %h want %h", i, bus.dout, e); end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [5];
        exp[0] = 8'hA0; exp[1] = 8'hA1; exp[2] = 8'hA2; exp[3] = 8'hA3; exp[4] = 8'hB0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.dout !== exp[i]) begin n_err++; $display("FAIL b2b_dout_%0d got %h want %h", i, bus.dout, exp[i]); end
            cycle(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
            n_cmp++;
            if (bus.count !== 5'd4) begin n_err++; $display("FAIL b2b_count_%0d got %0d want 4", i, bus.count); end
        end
        n_cmp++;
        if (bus.dout !== exp[4]) begin n_err++; $display("FAIL b2b_dout_4 got %h want %h", bus.dout, exp[4]); end
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_underflow();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp += 2;
        if (bus.unf !== 1'b1) begin n_err++; $display("FAIL unf_set got %b want 1", bus.unf); end
        if (bus.count !== 5'd0) begin n_err++; $display("FAIL unf_count got %0d want 0", bus.count); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        n_cmp += 3;
        if (bus.count !== 5'd1) begin n_err++; $display("FAIL unf_wr_count got %0d want 1", bus.count); end
        if (bus.dout !== 8'h5A) begin n_err++; $display("FAIL unf_wr_dout got %h want 5a", bus.dout); end
        if (bus.unf !== 1'b1) begin n_err++; $display("FAIL unf_reset got %b want 1", bus.unf); end
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            // Bias toward filling in the first half and draining in the second.
            bit w, r, c;
            w = ($urandom_range(99) < ((i % 200) < 100 ? 70 : 35));
            r = ($urandom_range(99) < ((i % 200) < 100 ? 35 : 70));
            c = ($urandom_range(99) < 5);
            cycle(w, 8'($urandom), r, c);
            n_cmp++;
            if (bus.dout !== m_dout() || bus.count !== 5'(mq.size()) ||
                bus.empty !== (mq.size() == 0) || bus.full !== (mq.size() == DEP) ||
                bus.almost_full !== (mq.size() >= AFULL) || bus.ovf !== m_ovf ||
                bus.unf !== m_unf) begin
                n_err++;
                $display("FAIL rand_%0d got dout=%h cnt=%0d e=%b f=%b af=%b o=%b u=%b want dout=%h cnt=%0d o=%b u=%b",
                         i, bus.dout, bus.count, bus.empty, bus.full, bus.almost_full, bus.ovf,
                         bus.unf, m_dout(), mq.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        bus.wr = 1'b0; bus.din = 8'h00; bus.rd = 1'b0; bus.clr_err = 1'b0;
        #12 rst_n = 1'b1;
        #1;
        test_reset();
        test_order();
        test_fill();
        test_full_rw();
        test_back_to_back();
        test_underflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
